// File: rtl/trap_ctrl.sv
// Machine-mode trap controller at the commit stage.
// Owns mstatus/mtvec/mepc/mcause and raises the flush/redirect pulse.
module trap_ctrl #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100,
    parameter int              NDRAIN      = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_in_valid,
    input  logic [XLEN-1:0] io_in_pc,
    input  logic            io_in_excpReq,
    input  logic [3:0]      io_in_excpCause,
    input  logic            io_in_mret,
    input  logic            io_in_extIrq,
    input  logic            io_in_csrWen,
    input  logic [11:0]     io_in_csrAddr,
    input  logic [XLEN-1:0] io_in_csrWdata,
    output logic [XLEN-1:0] io_out_csrRdata,
    output logic            io_out_excpValid,
    output logic [XLEN-1:0] io_out_redirectPc,
    output logic            io_out_mie
);

    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

    localparam logic [11:0]     A_MSTATUS  = 12'h300;
    localparam logic [11:0]     A_MTVEC    = 12'h305;
    localparam logic [11:0]     A_MEPC     = 12'h341;
    localparam logic [11:0]     A_MCAUSE   = 12'h342;
    localparam logic [XLEN-1:0] ALIGN      = ~XLEN'(3);
    localparam logic [XLEN-1:0] IRQ_CAUSE  = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
    localparam logic [3:0]      DRAIN_INIT = 4'(NDRAIN - 1);

    state_t          state;
    logic [3:0]      drain_cnt;
    logic            mie;
    logic            mpie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;

    logic act;
    logic irq_ok;
    logic take_excp;
    logic take_irq;
    logic take_mret;
    logic take_wen;
    logic take_trap;

    // Only one event acts per cycle, in strict priority order.
    assign act       = (state == IDLE) && io_in_valid;
    assign irq_ok    = io_in_extIrq && mie;
    assign take_excp = act && io_in_excpReq;
    assign take_irq  = act && !io_in_excpReq && irq_ok;
    assign take_mret = act && !io_in_excpReq && !irq_ok && io_in_mret;
    assign take_wen  = act && !io_in_excpReq && !irq_ok && !io_in_mret
                       && io_in_csrWen;
    assign take_trap = take_excp || take_irq;

    always_comb begin
        io_out_csrRdata = '0;
        case (io_in_csrAddr)
            A_MSTATUS: begin
                io_out_csrRdata[3] = mie;
                io_out_csrRdata[7] = mpie;
            end
            A_MTVEC:  io_out_csrRdata = mtvec;
            A_MEPC:   io_out_csrRdata = mepc;
            A_MCAUSE: io_out_csrRdata = mcause;
            default:  io_out_csrRdata = '0;
        endcase
    end

    assign io_out_mie = mie;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            drain_cnt         <= '0;
            mie               <= 1'b0;
            mpie              <= 1'b0;
            mtvec             <= MTVEC_RESET & ALIGN;
            mepc              <= '0;
            mcause            <= '0;
            io_out_excpValid  <= 1'b0;
            io_out_redirectPc <= '0;
        end else begin
            io_out_excpValid <= take_trap || take_mret;
            unique case (state)
                IDLE: begin
                    if (take_trap) begin
                        mepc              <= io_in_pc & ALIGN;
                        mcause            <= take_excp
                                             ? XLEN'(io_in_excpCause)
                                             : IRQ_CAUSE;
                        mpie              <= mie;
                        mie               <= 1'b0;
                        io_out_redirectPc <= mtvec;
                        state             <= REDIRECT;
                    end else if (take_mret) begin
                        io_out_redirectPc <= mepc;
                        mie               <= mpie;
                        mpie              <= 1'b1;
                        state             <= REDIRECT;
                    end else if (take_wen) begin
                        case (io_in_csrAddr)
                            A_MSTATUS: begin
                                mie  <= io_in_csrWdata[3];
                                mpie <= io_in_csrWdata[7];
                            end
                            A_MTVEC:  mtvec  <= io_in_csrWdata & ALIGN;
                            A_MEPC:   mepc   <= io_in_csrWdata & ALIGN;
                            A_MCAUSE: mcause <= io_in_csrWdata;
                            default:  ;
                        endcase
                    end
                end
                REDIRECT: begin
                    state     <= DRAIN;
                    drain_cnt <= DRAIN_INIT;
                end
                DRAIN: begin
                    if (drain_cnt == 4'd0) state <= IDLE;
                    else drain_cnt <= drain_cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: vector table, redirect scoreboard,
// and hand-written drain/reset sequences.
module tb_trap_ctrl;

    logic        clock;
    logic        reset;
    logic        io_in_valid;
    logic [31:0] io_in_pc;
    logic        io_in_excpReq;
    logic [3:0]  io_in_excpCause;
    logic        io_in_mret;
    logic        io_in_extIrq;
    logic        io_in_csrWen;
    logic [11:0] io_in_csrAddr;
    logic [31:0] io_in_csrWdata;
    logic [31:0] io_out_csrRdata;
    logic        io_out_excpValid;
    logic [31:0] io_out_redirectPc;
    logic        io_out_mie;

    trap_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .io_in_valid      (io_in_valid),
        .io_in_pc         (io_in_pc),
        .io_in_excpReq    (io_in_excpReq),
        .io_in_excpCause  (io_in_excpCause),
        .io_in_mret       (io_in_mret),
        .io_in_extIrq     (io_in_extIrq),
        .io_in_csrWen     (io_in_csrWen),
        .io_in_csrAddr    (io_in_csrAddr),
        .io_in_csrWdata   (io_in_csrWdata),
        .io_out_csrRdata  (io_out_csrRdata),
        .io_out_excpValid (io_out_excpValid),
        .io_out_redirectPc(io_out_redirectPc),
        .io_out_mie       (io_out_mie)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        excp;
        logic [3:0]  cause;
        logic        mret;
        logic        irq;
        logic        wen;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        pulse;
        logic [31:0] ppc;
        logic [11:0] caddr;
        logic [31:0] crd;
        logic        mie;
    } vec_t;

    vec_t        vecs[16];
    logic [31:0] sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic clear_in();
        io_in_valid     = 1'b0;
        io_in_pc        = 32'h0;
        io_in_excpReq   = 1'b0;
        io_in_excpCause = 4'h0;
        io_in_mret      = 1'b0;
        io_in_extIrq    = 1'b0;
        io_in_csrWen    = 1'b0;
        io_in_csrAddr   = 12'h0;
        io_in_csrWdata  = 32'h0;
    endtask

    task automatic read_chk(input string name, input logic [11:0] a,
                            input logic [31:0] exp);
        io_in_csrAddr = a;
        #1;
        chk(name, io_out_csrRdata, exp);
    endtask

    // Every observed pulse must match the oldest expected redirect.
    always @(negedge clock) begin
        if (!reset && io_out_excpValid) begin
            if (sb.size() == 0) chk("pulse_unexpected", 32'd1, 32'd0);
            else chk("redirect_pc", io_out_redirectPc, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h10, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 12'h305,
                     32'h200, 1'b0, 32'h0, 12'h305, 32'h200, 1'b0};
        vecs[1]  = '{1'b1, 32'h14, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 12'h300,
                     32'h8, 1'b0, 32'h0, 12'h300, 32'h8, 1'b1};
        vecs[2]  = '{1'b1, 32'h84, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 12'h0,
                     32'h0, 1'b1, 32'h200, 12'h341, 32'h84, 1'b0};
        vecs[3]  = '{1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 12'h0,
                     32'h0, 1'b0, 32'h0, 12'h342, 32'h2, 1'b0};
        vecs[4]  = '{1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 12'h0,
                     32'h0, 1'b0, 32'h0, 12'h300, 32'h80, 1'b0};
        vecs[5]  = '{1'b1, 32'h200, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 12'h0,
                     32'h0, 1'b1, 32'h84, 12'h300, 32'h88, 1'b1};
        vecs[6]  = '{1'b1, 32'h1000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 12'h0,
                     32'h0, 1'b1, 32'h200, 12'h342, 32'h8000_000B, 1'b0};
        vecs[7]  = '{1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 12'h0,
                     32'h0, 1'b0, 32'h0, 12'h341, 32'h1000, 1'b0};
        vecs[8]  = '{1'b1, 32'h2000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 12'h0,
                     32'h0, 1'b0, 32'h0, 12'h341, 32'h1000, 1'b0};
        vecs[9]  = '{1'b1, 32'h2004, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 12'h300,
                     32'h8, 1'b0, 32'h0, 12'h300, 32'h8, 1'b1};
        vecs[10] = '{1'b1, 32'h300, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 12'h305,
                     32'h400, 1'b1, 32'h200, 12'h305, 32'h200, 1'b0};
        vecs[11] = '{1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 12'h0,
                     32'h0, 1'b0, 32'h0, 12'h342, 32'h5, 1'b0};
        vecs[12] = '{1'b1, 32'h304, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 12'h305,
                     32'hFFFF_FFFF, 1'b0, 32'h0, 12'h305, 32'hFFFF_FFFC, 1'b0};
        vecs[13] = '{1'b1, 32'h308, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 12'h7C0,
                     32'h1234, 1'b0, 32'h0, 12'h7C0, 32'h0, 1'b0};
        vecs[14] = '{1'b1, 32'h30C, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 12'h342,
                     32'hDEAD_BEEF, 1'b0, 32'h0, 12'h342, 32'hDEAD_BEEF, 1'b0};
        vecs[15] = '{1'b1, 32'h310, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 12'h341,
                     32'h13, 1'b0, 32'h0, 12'h341, 32'h10, 1'b0};

        clear_in();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_excp_valid", 32'(io_out_excpValid), 32'd0);
        chk("rst_redirect_pc", io_out_redirectPc, 32'h0);
        chk("rst_mie", 32'(io_out_mie), 32'd0);
        read_chk("rst_mtvec", 12'h305, 32'h100);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            io_in_valid     = vecs[i].valid;
            io_in_pc        = vecs[i].pc;
            io_in_excpReq   = vecs[i].excp;
            io_in_excpCause = vecs[i].cause;
            io_in_mret      = vecs[i].mret;
            io_in_extIrq    = vecs[i].irq;
            io_in_csrWen    = vecs[i].wen;
            io_in_csrAddr   = vecs[i].addr;
            io_in_csrWdata  = vecs[i].wdata;
            @(posedge clock);
            if (vecs[i].pulse) sb.push_back(vecs[i].ppc);
            #1;
            clear_in();
            read_chk($sformatf("vec%0d_csr", i), vecs[i].caddr, vecs[i].crd);
            chk($sformatf("vec%0d_mie", i), 32'(io_out_mie), 32'(vecs[i].mie));
            repeat (4) @(posedge clock);
        end

        // Requests during the redirect and drain cycles are ignored.
        @(negedge clock);
        io_in_valid     = 1'b1;
        io_in_pc        = 32'h400;
        io_in_excpReq   = 1'b1;
        io_in_excpCause = 4'd1;
        io_in_csrAddr   = 12'h342;
        @(posedge clock);
        sb.push_back(32'hFFFF_FFFC);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            io_in_excpCause = 4'(3 + k);
            @(posedge clock);
        end
        #1;
        chk("drain_ignored_cause", io_out_csrRdata, 32'h1);
        @(negedge clock);
        io_in_excpCause = 4'd7;
        @(posedge clock);
        sb.push_back(32'hFFFF_FFFC);
        #1;
        chk("after_drain_cause", io_out_csrRdata, 32'h7);
        clear_in();
        repeat (4) @(posedge clock);

        // CSR writes during drain are dropped; first IDLE cycle takes it.
        @(negedge clock);
        io_in_valid     = 1'b1;
        io_in_pc        = 32'h500;
        io_in_excpReq   = 1'b1;
        io_in_excpCause = 4'd9;
        io_in_csrAddr   = 12'h342;
        @(posedge clock);
        sb.push_back(32'hFFFF_FFFC);
        @(negedge clock);
        io_in_excpReq  = 1'b0;
        io_in_csrWen   = 1'b1;
        io_in_csrWdata = 32'h55;
        repeat (3) @(posedge clock);
        #1;
        chk("drain_wen_dropped", io_out_csrRdata, 32'h9);
        @(posedge clock);
        #1;
        chk("idle_wen_taken", io_out_csrRdata, 32'h55);
        clear_in();
        repeat (2) @(posedge clock);

        // Reset while the redirect pulse is high.
        @(negedge clock);
        io_in_valid    = 1'b1;
        io_in_csrWen   = 1'b1;
        io_in_csrAddr  = 12'h300;
        io_in_csrWdata = 32'h8;
        @(negedge clock);
        clear_in();
        io_in_valid     = 1'b1;
        io_in_pc        = 32'h600;
        io_in_excpReq   = 1'b1;
        io_in_excpCause = 4'd3;
        @(posedge clock);
        #1;
        chk("pre_rst_pulse", 32'(io_out_excpValid), 32'd1);
        chk("pre_rst_pc", io_out_redirectPc, 32'hFFFF_FFFC);
        reset = 1'b1;
        #1;
        clear_in();
        chk("mid_rst_excp_valid", 32'(io_out_excpValid), 32'd0);
        chk("mid_rst_redirect_pc", io_out_redirectPc, 32'h0);
        chk("mid_rst_mie", 32'(io_out_mie), 32'd0);
        read_chk("mid_rst_mstatus", 12'h300, 32'h0);
        read_chk("mid_rst_mtvec", 12'h305, 32'h100);
        read_chk("mid_rst_mepc", 12'h341, 32'h0);
        read_chk("mid_rst_mcause", 12'h342, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(posedge clock);

        // Back in IDLE: a fresh exception goes to the reset mtvec.
        @(negedge clock);
        io_in_valid     = 1'b1;
        io_in_pc        = 32'h700;
        io_in_excpReq   = 1'b1;
        io_in_excpCause = 4'd4;
        @(posedge clock);
        sb.push_back(32'h100);
        #1;
        clear_in();
        read_chk("post_rst_mepc", 12'h341, 32'h700);
        repeat (5) @(posedge clock);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
